// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_adder_pkg
//  Description : Shared types and elaboration helpers for the pipelined adder.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_adder_pkg;

    // Per-stage handshake state: occupancy flag and carry out of the stage's top bit
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_hs_t;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        if (stages < 1 || stages > width) begin
            return 1'b0;
        end
        return (width % stages) == 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_adder_if
//  Description : Operand/result handshake bundle of the pipelined adder.
//                PIPE_ADDER_SUB_EN adds the sub request and ovf result.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_ADDER_SUB_EN
    logic             sub;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pipe_adder_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_adder_stage
//  Description : One CHUNK-bit slice of the pipelined carry chain with its
//                registers and local ready. PIPE_ADDER_SUB_EN adds o_ovf.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
`ifdef PIPE_ADDER_SUB_EN
    ,
    parameter bit LAST  = 1'b0
`endif
) (
    input  logic                              clk,
    input  logic                              rst,
    input  stage_hs_t                         i_hs,
    input  logic [2*WIDTH-IDX*CHUNK-1:0]      i_data,
    input  logic                              i_ready_next,
    output logic                              o_ready,
    output stage_hs_t                         o_hs,
    output logic [2*WIDTH-(IDX+1)*CHUNK-1:0]  o_data
`ifdef PIPE_ADDER_SUB_EN
    ,
    output logic                              o_ovf
`endif
);

    // Data word layout, MSB to LSB: {a_rest, b_rest, sum_lo}.
    // a_rest/b_rest start with this stage's chunk; sum_lo holds finished bits.
    localparam int c_IN_W  = 2*WIDTH - IDX*CHUNK;
    localparam int c_OUT_W = c_IN_W - CHUNK;
    localparam int c_LO_W  = IDX*CHUNK;
    localparam int c_REST  = WIDTH - IDX*CHUNK;

    localparam logic [c_IN_W-1:0] c_ONES      = {c_IN_W{1'b1}};
    localparam logic [c_IN_W-1:0] c_LO_MASK   = c_ONES >> (c_IN_W - c_LO_W);
    localparam logic [c_IN_W-1:0] c_B_UP_MASK =
        (c_ONES >> (c_IN_W - (c_REST - CHUNK))) << (c_LO_W + CHUNK);
    localparam logic [c_IN_W-1:0] c_A_UP_MASK = c_B_UP_MASK << c_REST;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_s;
    logic               w_carry;
    logic               w_load;
    logic [c_OUT_W-1:0] w_next;

    stage_hs_t          r_hs;
    logic [c_OUT_W-1:0] r_data;

    assign w_a_chunk = i_data[c_LO_W + c_REST +: CHUNK];
    assign w_b_chunk = i_data[c_LO_W +: CHUNK];

    assign {w_carry, w_s} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk}
                          + {{CHUNK{1'b0}}, i_hs.carry};

    // b_rest's upper part stays in place, a_rest's slides down by one chunk and
    // the new sum chunk takes the slot the consumed b chunk occupied.
    assign w_next = c_OUT_W'( ((i_data & c_A_UP_MASK) >> CHUNK)
                            | (i_data & c_B_UP_MASK)
                            | (c_IN_W'(w_s) << c_LO_W)
                            | (i_data & c_LO_MASK) );

    assign o_ready = !r_hs.valid || i_ready_next;
    assign w_load  = o_ready && i_hs.valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs   <= '0;
            r_data <= '0;
        end else if (o_ready) begin
            r_hs.valid <= i_hs.valid;
            if (i_hs.valid) begin
                r_hs.carry <= w_carry;
                r_data     <= w_next;
            end
        end
    end

    assign o_hs   = r_hs;
    assign o_data = r_data;

`ifdef PIPE_ADDER_SUB_EN
    generate
        if (LAST) begin : g_ovf
            logic r_ovf;

            // Carry into the MSB is recovered as s ^ a ^ b at that bit
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_load) begin
                    r_ovf <= w_s[CHUNK-1] ^ w_a_chunk[CHUNK-1]
                           ^ w_b_chunk[CHUNK-1] ^ w_carry;
                end
            end

            assign o_ovf = r_ovf;
        end else begin : g_no_ovf
            assign o_ovf = 1'b0;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_adder
//  Description : WIDTH-bit adder with carry-in/out, carry chain cut into
//                STAGES registered chunks under a valid/ready handshake.
//                Optional macro PIPE_ADDER_SUB_EN: subtract request and ovf.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    pipe_adder_if.slave  bus
);

    localparam int c_CHUNK = chunk_w(WIDTH, STAGES);

    generate
        if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
            $error("pipe_adder: STAGES must be in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [STAGES:0]  w_ready;
    stage_hs_t        w_hs [0:STAGES];

`ifdef PIPE_ADDER_SUB_EN
    logic [STAGES-1:0] w_ovf;

    // Subtraction is folded in at the entry, so only effective operands travel
    assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
    assign w_cin_eff = bus.sub | bus.cin;
`else
    assign w_b_eff   = bus.b;
    assign w_cin_eff = bus.cin;
`endif

    assign w_ready[STAGES] = bus.out_ready;
    assign w_hs[0]         = '{valid: bus.in_valid, carry: w_cin_eff};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [2*WIDTH-k*c_CHUNK-1:0]     w_din;
        logic [2*WIDTH-(k+1)*c_CHUNK-1:0] w_data;

        if (k == 0) begin : g_head
            assign w_din = {bus.a, w_b_eff};
        end else begin : g_body
            assign w_din = g_stage[k-1].w_data;
        end

        pipe_adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (c_CHUNK),
            .IDX   (k)
`ifdef PIPE_ADDER_SUB_EN
            ,
            .LAST  (k == STAGES - 1)
`endif
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .i_hs         (w_hs[k]),
            .i_data       (w_din),
            .i_ready_next (w_ready[k+1]),
            .o_ready      (w_ready[k]),
            .o_hs         (w_hs[k+1]),
            .o_data       (w_data)
`ifdef PIPE_ADDER_SUB_EN
            ,
            .o_ovf        (w_ovf[k])
`endif
        );
    end

    assign bus.in_ready  = w_ready[0];
    assign bus.out_valid = w_hs[STAGES].valid;
    assign bus.cout      = w_hs[STAGES].carry;
    assign bus.sum       = g_stage[STAGES-1].w_data;

`ifdef PIPE_ADDER_SUB_EN
    // Only the last stage drives a non-zero flag
    assign bus.ovf = |w_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_adder
//  Description : Self-checking bench for pipe_adder (WIDTH=32, STAGES=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_adder;

    localparam int W = 32;
    localparam int S = 4;
    localparam int N = 1000;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    res_t exp_q[$];

    pipe_adder_if #(.WIDTH(W)) bus ();

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W-1:0] b_eff;
        logic [W:0]   full;
        res_t         r;
        b_eff  = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, b_eff} + (W+1)'(sub ? 1'b1 : cin);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == b_eff[W-1]) && (r.sum[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic ordy);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.out_ready = ordy;
`ifdef PIPE_ADDER_SUB_EN
        bus.sub       = sub;
`else
        if (sub) bus.cin = cin;
`endif
    endtask

    task automatic tick(output logic in_acc, output logic out_acc,
                        output logic rdy, output res_t got);
        @(negedge clk);
        rdy      = bus.in_ready;
        in_acc   = bus.in_valid && bus.in_ready;
        out_acc  = bus.out_valid && bus.out_ready;
        got.sum  = bus.sum;
        got.cout = bus.cout;
`ifdef PIPE_ADDER_SUB_EN
        got.ovf  = bus.ovf;
`else
        got.ovf  = 1'b0;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic new_op(output logic [W-1:0] a, output logic [W-1:0] b,
                          output logic cin, output logic sub);
        a   = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
        b   = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
        cin = 1'($urandom_range(0, 1));
`ifdef PIPE_ADDER_SUB_EN
        sub = 1'($urandom_range(0, 1));
`else
        sub = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic ia, oa, rdy;
        res_t g;
        int   stale = 0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        else n_pass++;
        n_checks++;
        if (bus.sum !== '0 || bus.cout !== 1'b0)
            $display("FAIL reset_data: got sum=%h cout=%b expected sum=0 cout=0", bus.sum, bus.cout);
        else n_pass++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0);
            tick(ia, oa, rdy, g);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(ia, oa, rdy, g);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL midreset_state: got out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(ia, oa, rdy, g);
            if (oa) stale++;
        end
        n_checks++;
        if (stale != 0) $display("FAIL reset_stale: got %0d results expected 0", stale);
        else n_pass++;
    endtask

    task automatic test_carry();
        logic ia, oa, rdy;
        res_t g;
        int   outs = 0, first_t = -1;
        logic [W-1:0] exp_sum [2];
        exp_sum[0] = 32'h0000_0000;
        exp_sum[1] = 32'h0000_0001;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'(i), 1'b0, 1'b1);
            tick(ia, oa, rdy, g);
            n_checks++;
            if (ia !== 1'b1) $display("FAIL carry_accept%0d: got %b expected 1", i, ia);
            else n_pass++;
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int t = 2; t < 12 && outs < 2; t++) begin
            tick(ia, oa, rdy, g);
            if (oa) begin
                if (first_t < 0) first_t = t;
                n_checks++;
                if (g.sum !== exp_sum[outs] || g.cout !== 1'b1)
                    $display("FAIL carry_result%0d: got sum=%h cout=%b expected sum=%h cout=1",
                             outs, g.sum, g.cout, exp_sum[outs]);
                else n_pass++;
                outs++;
            end
        end
        n_checks++;
        if (first_t != S || outs != 2)
            $display("FAIL carry_latency: got first=%0d outs=%0d expected first=%0d outs=2", first_t, outs, S);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic ia, oa, rdy;
        res_t g, e;
        logic [W-1:0] pa, pb;
        logic pc, ps;
        int sent = 0, got_n = 0, first_t = -1, last_t = -1, gaps = 0;
        new_op(pa, pb, pc, ps);
        for (int t = 0; t < N + 50 && got_n < N; t++) begin
            drive(sent < N, pa, pb, pc, ps, 1'b1);
            tick(ia, oa, rdy, g);
            if (ia) begin
                exp_q.push_back(model(pa, pb, pc, ps));
                sent++;
                new_op(pa, pb, pc, ps);
            end
            if (oa) begin
                if (first_t < 0) first_t = t;
                else if (t != last_t + 1) gaps++;
                last_t = t;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: got sum=%h with no expected result", g.sum);
                end else begin
                    e = exp_q.pop_front();
                    if (g.sum !== e.sum || g.cout !== e.cout
`ifdef PIPE_ADDER_SUB_EN
                        || g.ovf !== e.ovf
`endif
                       )
                        $display("FAIL stream_result%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                                 got_n, g.sum, g.cout, g.ovf, e.sum, e.cout, e.ovf);
                    else n_pass++;
                end
                got_n++;
            end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (got_n != N || exp_q.size() != 0)
            $display("FAIL stream_count: got %0d results (%0d left) expected %0d", got_n, exp_q.size(), N);
        else n_pass++;
        n_checks++;
        if (first_t != S || gaps != 0)
            $display("FAIL stream_timing: got first=%0d gaps=%0d expected first=%0d gaps=0", first_t, gaps, S);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic ia, oa, rdy;
        res_t g, e;
        logic [W-1:0] pa, pb;
        logic pc, ps;
        int accepted = 0, outs = 0;
        new_op(pa, pb, pc, ps);
        for (int t = 0; t < 12; t++) begin
            drive(1'b1, pa, pb, pc, ps, 1'b0);
            tick(ia, oa, rdy, g);
            if (ia) begin
                exp_q.push_back(model(pa, pb, pc, ps));
                accepted++;
                new_op(pa, pb, pc, ps);
            end
        end
        n_checks++;
        if (accepted != S) $display("FAIL bp_accepted: got %0d expected %0d", accepted, S);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        for (int t = 0; t < 30 && (outs < S + 1); t++) begin
            drive(t == 0, pa, pb, pc, ps, 1'b1);
            tick(ia, oa, rdy, g);
            if (t == 0) begin
                n_checks++;
                if (ia !== 1'b1 || oa !== 1'b1)
                    $display("FAIL bp_full_passthru: got in=%b out=%b expected 1/1", ia, oa);
                else n_pass++;
            end
            if (ia) exp_q.push_back(model(pa, pb, pc, ps));
            if (oa) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL bp_extra: got sum=%h with no expected result", g.sum);
                end else begin
                    e = exp_q.pop_front();
                    if (g.sum !== e.sum || g.cout !== e.cout)
                        $display("FAIL bp_result%0d: got sum=%h cout=%b expected sum=%h cout=%b",
                                 outs, g.sum, g.cout, e.sum, e.cout);
                    else n_pass++;
                end
                outs++;
            end
        end
        n_checks++;
        if (outs != S + 1 || exp_q.size() != 0)
            $display("FAIL bp_drain: got %0d results (%0d left) expected %0d", outs, exp_q.size(), S + 1);
        else n_pass++;
    endtask

    task automatic test_bubbles();
        logic ia, oa, rdy, v;
        res_t g, e;
        logic [W-1:0] pa, pb;
        logic pc, ps;
        int n_acc = 0, rdy_low = 0, outs = 0;
        int out_t [2];
        out_t[0] = -1;
        out_t[1] = -1;
        for (int t = 0; t < 20; t++) begin
            v = (t == 0 || t == 3);
            if (v) new_op(pa, pb, pc, ps);
            drive(v, pa, pb, pc, ps, t >= 8);
            tick(ia, oa, rdy, g);
            if (t < 8 && !rdy) rdy_low++;
            if (ia) begin
                n_acc++;
                exp_q.push_back(model(pa, pb, pc, ps));
            end
            if (oa) begin
                if (outs < 2) out_t[outs] = t;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL bubble_extra: got sum=%h with no expected result", g.sum);
                end else begin
                    e = exp_q.pop_front();
                    if (g.sum !== e.sum || g.cout !== e.cout)
                        $display("FAIL bubble_result%0d: got sum=%h cout=%b expected sum=%h cout=%b",
                                 outs, g.sum, g.cout, e.sum, e.cout);
                    else n_pass++;
                end
                outs++;
            end
        end
        n_checks++;
        if (n_acc != 2 || rdy_low != 0)
            $display("FAIL bubble_accept: got accepted=%0d ready_low=%0d expected 2/0", n_acc, rdy_low);
        else n_pass++;
        n_checks++;
        if (outs != 2 || out_t[0] != 8 || out_t[1] != 9)
            $display("FAIL bubble_timing: got outs=%0d at %0d,%0d expected 2 at 8,9", outs, out_t[0], out_t[1]);
        else n_pass++;
    endtask

`ifdef PIPE_ADDER_SUB_EN
    task automatic test_sub();
        logic ia, oa, rdy;
        res_t g;
        int outs = 0;
        logic [W-1:0] op_a [2];
        logic [W-1:0] op_b [2];
        logic [W-1:0] x_sum [2];
        logic         x_cout [2];
        logic         x_ovf [2];
        op_a[0] = 32'd5;         op_b[0] = 32'd7; x_sum[0] = 32'hFFFF_FFFE; x_cout[0] = 1'b0; x_ovf[0] = 1'b0;
        op_a[1] = 32'h8000_0000; op_b[1] = 32'd1; x_sum[1] = 32'h7FFF_FFFF; x_cout[1] = 1'b1; x_ovf[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, op_a[i], op_b[i], 1'(i), 1'b1, 1'b1);
            tick(ia, oa, rdy, g);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 12 && outs < 2; t++) begin
            tick(ia, oa, rdy, g);
            if (oa) begin
                n_checks++;
                if (g.sum !== x_sum[outs] || g.cout !== x_cout[outs] || g.ovf !== x_ovf[outs])
                    $display("FAIL sub_result%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                             outs, g.sum, g.cout, g.ovf, x_sum[outs], x_cout[outs], x_ovf[outs]);
                else n_pass++;
                outs++;
            end
        end
        n_checks++;
        if (outs != 2) $display("FAIL sub_count: got %0d expected 2", outs);
        else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_carry();
        test_stream();
        test_backpressure();
        test_bubbles();
`ifdef PIPE_ADDER_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
